issue_scoreboard: RTL and testbench
===================================

# issue_scoreboard

Parametrised register scoreboard and issue-hazard controller for the multi-issue pipeline. It sits between decode and the issue/execute stages. It tracks in-flight long-latency writes (loads, mult/div, HI/LO, configurable as extra register indices) with per-register counters. Each cycle it grants an in-order prefix of the decode bundle. It also serialises CP0/TLB-class instructions so they execute with the back end fully drained.

## Interface
- `IW`, 2: issue slots per bundle; slot 0 is oldest.
- `NREG`, 34: tracked registers (0–31 GPR, 32 = HI, 33 = LO); index 0 is never tracked.
- `WBP`, 2: writeback/completion ports.
- `CNT_W`, 2: per-register counter width; MAXP = 2^CNT_W−1 in-flight long writes per register.
- Derived: RW = clog2(NREG); TOT_W = CNT_W + RW.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `pipe_stall`  in  1  back end frozen; no grants
- `flush`  in  1  kill current bundle / pending serial op
- `issue_valid`  in  IW  slot holds an instruction
- `issue_src_a`, `issue_src_b`  in  IW*RW  source indices
- `issue_use_a`, `issue_use_b`  in  IW  source actually read
- `issue_wen`  in  IW  slot writes `issue_dst`
- `issue_dst`  in  IW*RW  destination index
- `issue_long`  in  IW  write is long-latency (scoreboarded); ignored unless `issue_wen`
- `issue_serial`  in  IW  serialising instruction
- `wb_valid`  in  WBP  a long write completes (including killed ops)
- `wb_dst`  in  WBP*RW  completing register
- `serial_done`  in  1  granted serial op has retired
- `issue_grant`  out  IW  slot issues this cycle; always a prefix mask
- `stall`  out  1  `issue_valid[0] & ~issue_grant[0]`
- `inflight`  out  TOT_W  total scoreboarded writes outstanding
- `serial_busy`  out  1  FSM in SERIAL
- `underflow_err`  out  1  sticky: wb to a register whose count is 0

## Operation
- State: `cnt[NREG]` (CNT_W each), `inflight`, FSM {RUN, SERIAL}, `underflow_err`.
- Effective count: `eff[r] = cnt[r] − (number of wb ports with wb_valid and wb_dst==r)`, floored at 0. A source whose effective count is 0 is ready (WB bypass).
- Slot i is eligible when all of the following hold:
  - every used source with index ≠ 0 has `eff == 0`;
  - no older slot j<i in the bundle has `issue_wen` with `dst == src` (index ≠ 0);
  - if i writes long, then `eff[dst]` plus the long writes to the same dst from older granted slots is < MAXP;
  - if i is serial, then i == 0, effective inflight == 0, and no wb is pending beyond this cycle.
- A serial op in slot 0 grants alone; slots ≥1 are denied. A serial op in slot i>0 denies slots ≥ i.
- `issue_grant[i]` = eligible(i) & valid(i) & grant[i−1]. The whole grant is 0 when any of these holds: `pipe_stall`, `flush`, `reset`, or state SERIAL.
- Update at the clock edge: `cnt[r] += granted long writers to r − wb hits on r`. `inflight` is updated the same way with all writers and hits summed.
- A wb with `cnt==0` sets `underflow_err`; the counter stays 0.
- Killed long ops still report `wb_valid`, so counters stay exact across flush. `flush` does not clear counters.
- FSM transitions:
  - RUN → SERIAL on a granted serial op.
  - SERIAL → RUN on `serial_done` or `flush`.
  - `serial_done` while in RUN is ignored.
- Reset (any cycle, including mid-SERIAL): all `cnt` = 0, `inflight` = 0, state RUN, `underflow_err` = 0.

## Timing
- `issue_grant` and `stall` are combinational from inputs and registered state; there is no flop between decode and grant.
- Counter effect is visible from the cycle after issue. A writeback's effect is visible in the same cycle, through the bypass.
- Load-use distance: a consumer stalls from the cycle after the long producer issues until the wb cycle. It grants in the wb cycle.
- `serial_busy` rises the cycle after the serial grant. Grants stay 0 through the `serial_done` cycle and resume the following cycle.
- Reset outputs: `issue_grant` = 0, `stall` = `issue_valid[0]`, `inflight` = 0, `serial_busy` = 0, `underflow_err` = 0.
- Simultaneous issue and wb on the same register in one cycle: net update; a counter at MAXP with one wb admits one new long writer.

## Test plan
- RAW stall and bypass (IW=2):
  - Long write r5 granted in cycle 0; cycle 1 slot 0 reads r5 → grant 00, stall 1.
  - Cycle 3 wb r5 → grant 01 in the same cycle; cnt[5] = 0 after the edge.
- Intra-bundle dependency:
  - Slot 0 writes r3 (short), slot 1 reads r3 → grant 01.
  - Slot 1 reads r0 instead → grant 11.
- Saturation (CNT_W=2):
  - Three long writes to r7 in consecutive cycles → all granted; the fourth → 00.
  - In the cycle with wb r7 plus a new long r7 write → granted; cnt stays 3.
- Serialisation:
  - inflight=1, serial op in slot 0 → 00 until the wb cycle, then grant 01; next cycle serial_busy=1 and grants 00.
  - serial_done in cycle N → grants resume in N+1.
- Underflow: wb r9 with cnt[9]=0 → underflow_err=1, held until reset; cnt[9] stays 0; inflight unchanged.
- Reset mid-SERIAL with cnt[4]=2 → next cycle serial_busy=0, inflight=0, and a read of r4 is granted.

Source files
------------

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: per-register scoreboard for long-latency writes, in-order
// prefix issue of a decode bundle, and drain-then-execute serialisation of
// CP0/TLB-class instructions.
module issue_scoreboard #(
   parameter  int IW    = 2,
   parameter  int NREG  = 34,
   parameter  int WBP   = 2,
   parameter  int CNT_W = 2,
   localparam int RW    = $clog2(NREG),
   localparam int TOT_W = CNT_W + RW
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pipe_stall,
   input  logic               flush,
   input  logic [IW-1:0]      issue_valid,
   input  logic [IW*RW-1:0]   issue_src_a,
   input  logic [IW*RW-1:0]   issue_src_b,
   input  logic [IW-1:0]      issue_use_a,
   input  logic [IW-1:0]      issue_use_b,
   input  logic [IW-1:0]      issue_wen,
   input  logic [IW*RW-1:0]   issue_dst,
   input  logic [IW-1:0]      issue_long,
   input  logic [IW-1:0]      issue_serial,
   input  logic [WBP-1:0]     wb_valid,
   input  logic [WBP*RW-1:0]  wb_dst,
   input  logic               serial_done,
   output logic [IW-1:0]      issue_grant,
   output logic               stall,
   output logic [TOT_W-1:0]   inflight,
   output logic               serial_busy,
   output logic               underflow_err
);

   localparam int               NIDX   = 1 << RW;
   localparam logic [TOT_W-1:0] ONE    = TOT_W'(1);
   localparam logic [TOT_W-1:0] MAXP   = TOT_W'((1 << CNT_W) - 1);
   localparam logic [RW:0]      NREG_L = (RW+1)'(NREG);

   typedef enum logic {RUN, SERIAL} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q [NREG];
   logic [CNT_W-1:0] cnt_d [NREG];
   logic [TOT_W-1:0] inflight_q, inflight_d;
   logic             underflow_q, underflow_d;

   logic [TOT_W-1:0] hits [NREG];
   logic [TOT_W-1:0] dec  [NREG];
   logic [TOT_W-1:0] inc  [NREG];
   logic [TOT_W-1:0] eff  [NIDX];
   logic [TOT_W-1:0] decTotal, incTotal, effInflight;
   logic             anyUnderflow;

   logic [IW-1:0]    grant;
   logic             blockAll, prevOk, slotOk;
   logic [RW-1:0]    srcA, srcB, dstI, dstJ;
   logic [TOT_W-1:0] pend;

   // Only real registers 1..NREG-1 are scoreboarded; r0 and unused encodings are always ready.
   function automatic logic isTracked(input logic [RW-1:0] idx);
      return (idx != '0) && ({1'b0, idx} < NREG_L);
   endfunction

   // Writeback bypass: fold this cycle's completions into an effective count per register.
   // A completion to a zero counter is an underflow and removes nothing.
   always_comb begin
      decTotal     = '0;
      anyUnderflow = 1'b0;
      for (int r = 0; r < NIDX; r++) begin
         eff[r] = '0;
      end
      for (int r = 0; r < NREG; r++) begin
         hits[r] = '0;
         dec[r]  = '0;
         if (r != 0) begin
            for (int p = 0; p < WBP; p++) begin
               if (wb_valid[p] && (wb_dst[p*RW +: RW] == RW'(r))) begin
                  hits[r] = hits[r] + ONE;
               end
            end
            if (hits[r] > TOT_W'(cnt_q[r])) begin
               dec[r]       = TOT_W'(cnt_q[r]);
               anyUnderflow = 1'b1;
            end else begin
               dec[r] = hits[r];
            end
            eff[r]   = TOT_W'(cnt_q[r]) - dec[r];
            decTotal = decTotal + dec[r];
         end
      end
      effInflight = (inflight_q > decTotal) ? (inflight_q - decTotal) : '0;
   end

   // Grant the longest in-order prefix of ready slots; a denied slot blocks all younger ones.
   always_comb begin
      blockAll = reset | pipe_stall | flush | (state_q == SERIAL);
      grant    = '0;
      prevOk   = ~blockAll;
      srcA     = '0;
      srcB     = '0;
      dstI     = '0;
      dstJ     = '0;
      pend     = '0;
      slotOk   = 1'b0;
      for (int i = 0; i < IW; i++) begin
         srcA   = issue_src_a[i*RW +: RW];
         srcB   = issue_src_b[i*RW +: RW];
         dstI   = issue_dst[i*RW +: RW];
         slotOk = prevOk & issue_valid[i];
         if (issue_use_a[i] && (srcA != '0) && (eff[srcA] != '0)) slotOk = 1'b0;
         if (issue_use_b[i] && (srcB != '0) && (eff[srcB] != '0)) slotOk = 1'b0;
         pend = '0;
         if (issue_wen[i] && issue_long[i] && isTracked(dstI)) pend = eff[dstI];
         for (int j = 0; j < i; j++) begin
            dstJ = issue_dst[j*RW +: RW];
            if (issue_wen[j] && (dstJ != '0)) begin
               if (issue_use_a[i] && (dstJ == srcA)) slotOk = 1'b0;
               if (issue_use_b[i] && (dstJ == srcB)) slotOk = 1'b0;
               if (issue_long[j] && issue_wen[i] && issue_long[i] && (dstJ == dstI)) pend = pend + ONE;
            end
         end
         if (issue_wen[i] && issue_long[i] && isTracked(dstI) && (pend >= MAXP)) slotOk = 1'b0;
         if (issue_serial[i] && ((i != 0) || (effInflight != '0))) slotOk = 1'b0;
         if ((i != 0) && issue_serial[0]) slotOk = 1'b0;
         grant[i] = slotOk;
         prevOk   = slotOk;
      end
   end

   // Next counter values: granted long writers add, bypassed completions subtract, net per register.
   always_comb begin
      incTotal = '0;
      for (int r = 0; r < NREG; r++) begin
         inc[r] = '0;
         if (r != 0) begin
            for (int i = 0; i < IW; i++) begin
               if (grant[i] && issue_wen[i] && issue_long[i] && (issue_dst[i*RW +: RW] == RW'(r))) begin
                  inc[r] = inc[r] + ONE;
               end
            end
         end
         cnt_d[r] = CNT_W'(TOT_W'(cnt_q[r]) - dec[r] + inc[r]);
         incTotal = incTotal + inc[r];
      end
      inflight_d  = inflight_q + incTotal - decTotal;
      underflow_d = underflow_q | anyUnderflow;
   end

   // Scoreboard state; flush leaves counters alone because killed ops still report completion.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NREG; r++) begin
            cnt_q[r] <= '0;
         end
         inflight_q  <= '0;
         underflow_q <= 1'b0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         inflight_q  <= inflight_d;
         underflow_q <= underflow_d;
      end
   end

   // Serialisation FSM: park in SERIAL after a serial grant until it retires or is flushed.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
      end else begin
         case (state_q)
            RUN:     if (grant[0] && issue_serial[0]) state_q <= SERIAL;
            SERIAL:  if (serial_done || flush)        state_q <= RUN;
            default: state_q <= RUN;
         endcase
      end
   end

   assign issue_grant   = grant;
   assign stall         = issue_valid[0] & ~grant[0];
   assign inflight      = inflight_q;
   assign serial_busy   = (state_q == SERIAL);
   assign underflow_err = underflow_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: each scenario queues the expected
// outputs per cycle, samples the DUT at the falling edge, then compares.
module tb_issue_scoreboard;

   localparam int IW    = 2;
   localparam int NREG  = 34;
   localparam int WBP   = 2;
   localparam int CNT_W = 2;
   localparam int RW    = 6;
   localparam int TOT_W = 8;

   logic               clk = 1'b0;
   logic               reset;
   logic               pipe_stall;
   logic               flush;
   logic [IW-1:0]      issue_valid;
   logic [IW*RW-1:0]   issue_src_a;
   logic [IW*RW-1:0]   issue_src_b;
   logic [IW-1:0]      issue_use_a;
   logic [IW-1:0]      issue_use_b;
   logic [IW-1:0]      issue_wen;
   logic [IW*RW-1:0]   issue_dst;
   logic [IW-1:0]      issue_long;
   logic [IW-1:0]      issue_serial;
   logic [WBP-1:0]     wb_valid;
   logic [WBP*RW-1:0]  wb_dst;
   logic               serial_done;
   logic [IW-1:0]      issue_grant;
   logic               stall;
   logic [TOT_W-1:0]   inflight;
   logic               serial_busy;
   logic               underflow_err;

   typedef struct packed {
      logic [1:0]       grant;
      logic             stall;
      logic [TOT_W-1:0] inflight;
      logic             busy;
      logic             uerr;
   } snap_t;

   snap_t expQ[$];
   snap_t obsQ[$];
   int    checks   = 0;
   int    failures = 0;

   issue_scoreboard #(.IW(IW), .NREG(NREG), .WBP(WBP), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .pipe_stall    (pipe_stall),
      .flush         (flush),
      .issue_valid   (issue_valid),
      .issue_src_a   (issue_src_a),
      .issue_src_b   (issue_src_b),
      .issue_use_a   (issue_use_a),
      .issue_use_b   (issue_use_b),
      .issue_wen     (issue_wen),
      .issue_dst     (issue_dst),
      .issue_long    (issue_long),
      .issue_serial  (issue_serial),
      .wb_valid      (wb_valid),
      .wb_dst        (wb_dst),
      .serial_done   (serial_done),
      .issue_grant   (issue_grant),
      .stall         (stall),
      .inflight      (inflight),
      .serial_busy   (serial_busy),
      .underflow_err (underflow_err)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   task automatic clearInputs();
      pipe_stall   = 1'b0;
      flush        = 1'b0;
      issue_valid  = '0;
      issue_src_a  = '0;
      issue_src_b  = '0;
      issue_use_a  = '0;
      issue_use_b  = '0;
      issue_wen    = '0;
      issue_dst    = '0;
      issue_long   = '0;
      issue_serial = '0;
      wb_valid     = '0;
      wb_dst       = '0;
      serial_done  = 1'b0;
   endtask

   task automatic applyStimulus(input int i, input logic [RW-1:0] srcA, input logic useA,
                                input logic [RW-1:0] srcB, input logic useB, input logic wen,
                                input logic [RW-1:0] dst, input logic lng, input logic ser);
      issue_valid[i]           = 1'b1;
      issue_src_a[i*RW +: RW]  = srcA;
      issue_use_a[i]           = useA;
      issue_src_b[i*RW +: RW]  = srcB;
      issue_use_b[i]           = useB;
      issue_wen[i]             = wen;
      issue_dst[i*RW +: RW]    = dst;
      issue_long[i]            = lng;
      issue_serial[i]          = ser;
   endtask

   task automatic setWb(input int p, input logic [RW-1:0] dst);
      wb_valid[p]         = 1'b1;
      wb_dst[p*RW +: RW]  = dst;
   endtask

   task automatic pushExpected(input logic [1:0] g, input logic s, input logic [TOT_W-1:0] inf,
                               input logic b, input logic u);
      snap_t e;
      e.grant    = g;
      e.stall    = s;
      e.inflight = inf;
      e.busy     = b;
      e.uerr     = u;
      expQ.push_back(e);
   endtask

   task automatic stepCycle();
      snap_t o;
      @(negedge clk);
      o.grant    = issue_grant;
      o.stall    = stall;
      o.inflight = inflight;
      o.busy     = serial_busy;
      o.uerr     = underflow_err;
      obsQ.push_back(o);
      @(posedge clk);
      #1;
      clearInputs();
   endtask

   task automatic test_reset();
      snap_t e, o;
      int step = 0;
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      pushExpected(2'b00, 1, 0, 0, 0); stepCycle();
      reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      pushExpected(2'b01, 0, 0, 0, 0); stepCycle();
      while (expQ.size() != 0) begin
         e = expQ.pop_front();
         checks++;
         if (obsQ.size() == 0) begin
            failures++; $display("[TB] FAIL reset step %0d: no sample", step);
         end else begin
            o = obsQ.pop_front();
            if (o !== e) begin
               failures++;
               $display("[TB] FAIL reset step %0d: got g=%b st=%b inf=%0d busy=%b uerr=%b, want g=%b st=%b inf=%0d busy=%b uerr=%b",
                        step, o.grant, o.stall, o.inflight, o.busy, o.uerr, e.grant, e.stall, e.inflight, e.busy, e.uerr);
            end
         end
         step++;
      end
   endtask

   task automatic test_raw_bypass();
      snap_t e, o;
      int step = 0;
      applyStimulus(0, 0, 0, 0, 0, 1, 5, 1, 0);
      pushExpected(2'b01, 0, 0, 0, 0); stepCycle();
      for (int c = 0; c < 2; c++) begin
         applyStimulus(0, 5, 1, 0, 0, 0, 0, 0, 0);
         pushExpected(2'b00, 1, 1, 0, 0); stepCycle();
      end
      applyStimulus(0, 5, 1, 0, 0, 0, 0, 0, 0);
      setWb(0, 5);
      pushExpected(2'b01, 0, 1, 0, 0); stepCycle();
      applyStimulus(0, 5, 1, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 5, 1, 0, 0, 0, 0);
      pushExpected(2'b11, 0, 0, 0, 0); stepCycle();
      while (expQ.size() != 0) begin
         e = expQ.pop_front();
         checks++;
         if (obsQ.size() == 0) begin
            failures++; $display("[TB] FAIL raw_bypass step %0d: no sample", step);
         end else begin
            o = obsQ.pop_front();
            if (o !== e) begin
               failures++;
               $display("[TB] FAIL raw_bypass step %0d: got g=%b st=%b inf=%0d busy=%b uerr=%b, want g=%b st=%b inf=%0d busy=%b uerr=%b",
                        step, o.grant, o.stall, o.inflight, o.busy, o.uerr, e.grant, e.stall, e.inflight, e.busy, e.uerr);
            end
         end
         step++;
      end
   endtask

   task automatic test_intra_bundle();
      snap_t e, o;
      int step = 0;
      applyStimulus(0, 0, 0, 0, 0, 1, 3, 0, 0);
      applyStimulus(1, 0, 0, 3, 1, 0, 0, 0, 0);
      pushExpected(2'b01, 0, 0, 0, 0); stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 1, 3, 0, 0);
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0);
      pushExpected(2'b11, 0, 0, 0, 0); stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 1, 3, 0, 0);
      applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0);
      pushExpected(2'b11, 0, 0, 0, 0); stepCycle();
      pipe_stall = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      pushExpected(2'b00, 1, 0, 0, 0); stepCycle();
      flush = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      pushExpected(2'b00, 1, 0, 0, 0); stepCycle();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      pushExpected(2'b00, 0, 0, 0, 0); stepCycle();
      while (expQ.size() != 0) begin
         e = expQ.pop_front();
         checks++;
         if (obsQ.size() == 0) begin
            failures++; $display("[TB] FAIL intra_bundle step %0d: no sample", step);
         end else begin
            o = obsQ.pop_front();
            if (o !== e) begin
               failures++;
               $display("[TB] FAIL intra_bundle step %0d: got g=%b st=%b inf=%0d busy=%b uerr=%b, want g=%b st=%b inf=%0d busy=%b uerr=%b",
                        step, o.grant, o.stall, o.inflight, o.busy, o.uerr, e.grant, e.stall, e.inflight, e.busy, e.uerr);
            end
         end
         step++;
      end
   endtask

   task automatic test_saturation();
      snap_t e, o;
      int step = 0;
      for (int c = 0; c < 3; c++) begin
         applyStimulus(0, 0, 0, 0, 0, 1, 7, 1, 0);
         pushExpected(2'b01, 0, TOT_W'(c), 0, 0); stepCycle();
      end
      applyStimulus(0, 0, 0, 0, 0, 1, 7, 1, 0);
      pushExpected(2'b00, 1, 3, 0, 0); stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 1, 7, 1, 0);
      setWb(0, 7);
      pushExpected(2'b01, 0, 3, 0, 0); stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 1, 7, 1, 0);
      pushExpected(2'b00, 1, 3, 0, 0); stepCycle();
      setWb(0, 7); setWb(1, 7);
      pushExpected(2'b00, 0, 3, 0, 0); stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 1, 7, 1, 0);
      applyStimulus(1, 0, 0, 0, 0, 1, 7, 1, 0);
      pushExpected(2'b11, 0, 1, 0, 0); stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 1, 7, 1, 0);
      applyStimulus(1, 0, 0, 0, 0, 1, 7, 1, 0);
      setWb(0, 7);
      pushExpected(2'b01, 0, 3, 0, 0); stepCycle();
      setWb(0, 7); setWb(1, 7);
      pushExpected(2'b00, 0, 3, 0, 0); stepCycle();
      setWb(1, 7);
      pushExpected(2'b00, 0, 1, 0, 0); stepCycle();
      pushExpected(2'b00, 0, 0, 0, 0); stepCycle();
      while (expQ.size() != 0) begin
         e = expQ.pop_front();
         checks++;
         if (obsQ.size() == 0) begin
            failures++; $display("[TB] FAIL saturation step %0d: no sample", step);
         end else begin
            o = obsQ.pop_front();
            if (o !== e) begin
               failures++;
               $display("[TB] FAIL saturation step %0d: got g=%b st=%b inf=%0d busy=%b uerr=%b, want g=%b st=%b inf=%0d busy=%b uerr=%b",
                        step, o.grant, o.stall, o.inflight, o.busy, o.uerr, e.grant, e.stall, e.inflight, e.busy, e.uerr);
            end
         end
         step++;
      end
   endtask

   task automatic test_serial();
      snap_t e, o;
      int step = 0;
      applyStimulus(0, 0, 0, 0, 0, 1, 10, 1, 0);
      pushExpected(2'b01, 0, 0, 0, 0); stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      pushExpected(2'b00, 1, 1, 0, 0); stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      setWb(0, 10);
      pushExpected(2'b01, 0, 1, 0, 0); stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      pushExpected(2'b00, 1, 0, 1, 0); stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      serial_done = 1'b1;
      pushExpected(2'b00, 1, 0, 1, 0); stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      pushExpected(2'b11, 0, 0, 0, 0); stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
      pushExpected(2'b01, 0, 0, 0, 0); stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      pushExpected(2'b01, 0, 0, 0, 0); stepCycle();
      flush = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      pushExpected(2'b00, 1, 0, 1, 0); stepCycle();
      serial_done = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      pushExpected(2'b01, 0, 0, 0, 0); stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      pushExpected(2'b01, 0, 0, 0, 0); stepCycle();
      while (expQ.size() != 0) begin
         e = expQ.pop_front();
         checks++;
         if (obsQ.size() == 0) begin
            failures++; $display("[TB] FAIL serial step %0d: no sample", step);
         end else begin
            o = obsQ.pop_front();
            if (o !== e) begin
               failures++;
               $display("[TB] FAIL serial step %0d: got g=%b st=%b inf=%0d busy=%b uerr=%b, want g=%b st=%b inf=%0d busy=%b uerr=%b",
                        step, o.grant, o.stall, o.inflight, o.busy, o.uerr, e.grant, e.stall, e.inflight, e.busy, e.uerr);
            end
         end
         step++;
      end
   endtask

   task automatic test_underflow();
      snap_t e, o;
      int step = 0;
      setWb(1, 9);
      pushExpected(2'b00, 0, 0, 0, 0); stepCycle();
      applyStimulus(0, 9, 1, 0, 0, 0, 0, 0, 0);
      pushExpected(2'b01, 0, 0, 0, 1); stepCycle();
      pushExpected(2'b00, 0, 0, 0, 1); stepCycle();
      while (expQ.size() != 0) begin
         e = expQ.pop_front();
         checks++;
         if (obsQ.size() == 0) begin
            failures++; $display("[TB] FAIL underflow step %0d: no sample", step);
         end else begin
            o = obsQ.pop_front();
            if (o !== e) begin
               failures++;
               $display("[TB] FAIL underflow step %0d: got g=%b st=%b inf=%0d busy=%b uerr=%b, want g=%b st=%b inf=%0d busy=%b uerr=%b",
                        step, o.grant, o.stall, o.inflight, o.busy, o.uerr, e.grant, e.stall, e.inflight, e.busy, e.uerr);
            end
         end
         step++;
      end
   endtask

   task automatic test_reset_mid_serial();
      snap_t e, o;
      int step = 0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      pushExpected(2'b01, 0, 0, 0, 1); stepCycle();
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      pushExpected(2'b00, 1, 0, 1, 1); stepCycle();
      reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      pushExpected(2'b01, 0, 0, 0, 0); stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 1, 4, 1, 0);
      pushExpected(2'b01, 0, 0, 0, 0); stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 1, 4, 1, 0);
      pushExpected(2'b01, 0, 1, 0, 0); stepCycle();
      applyStimulus(0, 4, 1, 0, 0, 0, 0, 0, 0);
      pushExpected(2'b00, 1, 2, 0, 0); stepCycle();
      reset = 1'b1;
      applyStimulus(0, 4, 1, 0, 0, 0, 0, 0, 0);
      pushExpected(2'b00, 1, 2, 0, 0); stepCycle();
      reset = 1'b0;
      applyStimulus(0, 4, 1, 0, 0, 0, 0, 0, 0);
      pushExpected(2'b01, 0, 0, 0, 0); stepCycle();
      while (expQ.size() != 0) begin
         e = expQ.pop_front();
         checks++;
         if (obsQ.size() == 0) begin
            failures++; $display("[TB] FAIL reset_mid_serial step %0d: no sample", step);
         end else begin
            o = obsQ.pop_front();
            if (o !== e) begin
               failures++;
               $display("[TB] FAIL reset_mid_serial step %0d: got g=%b st=%b inf=%0d busy=%b uerr=%b, want g=%b st=%b inf=%0d busy=%b uerr=%b",
                        step, o.grant, o.stall, o.inflight, o.busy, o.uerr, e.grant, e.stall, e.inflight, e.busy, e.uerr);
            end
         end
         step++;
      end
   endtask

   // Scenario sequence; each scenario starts from the state the previous one left behind.
   initial begin
      reset = 1'b1;
      clearInputs();
      @(posedge clk);
      #1;
      $display("[TB] starting issue_scoreboard scenarios");
      test_reset();
      test_raw_bypass();
      test_intra_bundle();
      test_saturation();
      test_serial();
      test_underflow();
      test_reset_mid_serial();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
